ped_request_conditioner: RTL and testbench

//  Conditions the four raw pedestrian crossing buttons before they reach the intersection FSM.
//  Per button: 2-FF synchronizer, then a debouncer.

---
 rtl/ped_request_conditioner_pkg.sv | 27 ++
 rtl/ped_request_conditioner_if.sv | 24 ++
 rtl/ped_request_conditioner_btn_debounce.sv | 104 ++++++++++
 rtl/ped_request_conditioner.sv | 102 ++++++++++
 tb/tb_ped_request_conditioner.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ped_request_conditioner_pkg.sv
// Shared constants for the pedestrian request conditioner: debounce state
// encodings, button indices and the button-to-axis masks.
package ped_req_pkg;

  localparam int NUM_BTN = 4;

  typedef logic [NUM_BTN-1:0] btn_vec_t;
  typedef logic [1:0]         db_state_t;

  localparam db_state_t IDLE_LO = 2'd0;
  localparam db_state_t WAIT_HI = 2'd1;
  localparam db_state_t IDLE_HI = 2'd2;
  localparam db_state_t WAIT_LO = 2'd3;

  localparam int BTN_EW0 = 0;
  localparam int BTN_NS1 = 1;
  localparam int BTN_EW2 = 2;
  localparam int BTN_NS3 = 3;

  localparam btn_vec_t NS_MASK = 4'b1010;
  localparam btn_vec_t EW_MASK = 4'b0101;

  function automatic logic axis_hit(input btn_vec_t pulses, input btn_vec_t mask);
    return |(pulses & mask);
  endfunction

endpackage

// File: rtl/ped_request_conditioner_if.sv
// Button/request bundle between the button conditioner (slave) and the
// intersection controller side that drives raw buttons and acknowledges (master).
interface ped_request_conditioner_if;
  import ped_req_pkg::*;

  btn_vec_t btn_raw;
  logic     clear_ns;
  logic     clear_ew;
  btn_vec_t btn_level;
  btn_vec_t press_pulse;
  logic     ns_req;
  logic     ew_req;

  modport master (
    output btn_raw, clear_ns, clear_ew,
    input  btn_level, press_pulse, ns_req, ew_req
  );

  modport slave (
    input  btn_raw, clear_ns, clear_ew,
    output btn_level, press_pulse, ns_req, ew_req
  );

endinterface

// File: rtl/ped_request_conditioner_btn_debounce.sv
// One button: 2-FF synchronizer followed by a counting debounce FSM that emits
// a registered level and a one-cycle pulse on each accepted press.
//
// state   | meaning
// IDLE_LO | stable released, waiting for a high sample
// WAIT_HI | counting consecutive high samples
// IDLE_HI | stable pressed, waiting for a low sample
// WAIT_LO | counting consecutive low samples
module btn_debounce
  import ped_req_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic CCLK,
  input  logic reset,
  input  logic btn_raw_i,
  output logic level_o,
  output logic pulse_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;

  always_ff @(posedge CCLK) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // Entering a WAIT state already counts the first stable sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE_LO: begin
        if (sync2_q) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!sync2_q) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!sync2_q) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (sync2_q) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    level_d = (state_d == IDLE_HI) || (state_d == WAIT_LO);
    pulse_d = (state_q == WAIT_HI) && (state_d == IDLE_HI);
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/ped_request_conditioner.sv
// Debounces four pedestrian buttons and folds accepted presses into sticky
// per-axis requests. Optional re-arm lockout: PED_REQ_LOCKOUT_EN.
module ped_request_conditioner
  import ped_req_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int LOCKOUT_CYCLES  = 1000000
) (
  input  logic                       CCLK,
  input  logic                       reset,
  ped_request_conditioner_if.slave   bus
);

  btn_vec_t level;
  btn_vec_t pulse;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .CCLK      (CCLK),
      .reset     (reset),
      .btn_raw_i (bus.btn_raw[i]),
      .level_o   (level[i]),
      .pulse_o   (pulse[i])
    );
  end

  logic set_ns, set_ew;
  logic acc_ns, acc_ew;
  logic ns_req_q, ns_req_d;
  logic ew_req_q, ew_req_d;

  assign set_ns = axis_hit(pulse, NS_MASK);
  assign set_ew = axis_hit(pulse, EW_MASK);

`ifdef PED_REQ_LOCKOUT_EN
  localparam int                LOCK_W    = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES);
  localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);

  logic [LOCK_W-1:0] lock_ns_q, lock_ns_d;
  logic [LOCK_W-1:0] lock_ew_q, lock_ew_d;
  logic              start_ns, start_ew;

  // A clear that actually services a request starts the lockout and also
  // swallows any press arriving in the same cycle.
  always_comb begin
    start_ns  = bus.clear_ns & ns_req_q;
    start_ew  = bus.clear_ew & ew_req_q;
    acc_ns    = set_ns & ~start_ns & (lock_ns_q == '0);
    acc_ew    = set_ew & ~start_ew & (lock_ew_q == '0);
    lock_ns_d = lock_ns_q;
    lock_ew_d = lock_ew_q;
    if (start_ns)               lock_ns_d = LOCK_LOAD;
    else if (lock_ns_q != '0)   lock_ns_d = lock_ns_q - LOCK_ONE;
    if (start_ew)               lock_ew_d = LOCK_LOAD;
    else if (lock_ew_q != '0)   lock_ew_d = lock_ew_q - LOCK_ONE;
  end

  always_ff @(posedge CCLK) begin
    if (reset) begin
      lock_ns_q <= '0;
      lock_ew_q <= '0;
    end else begin
      lock_ns_q <= lock_ns_d;
      lock_ew_q <= lock_ew_d;
    end
  end
`else
  assign acc_ns = set_ns;
  assign acc_ew = set_ew;
`endif

  // Set has priority over clear so a press coinciding with an ack is not lost.
  always_comb begin
    ns_req_d = ns_req_q;
    ew_req_d = ew_req_q;
    if (acc_ns)            ns_req_d = 1'b1;
    else if (bus.clear_ns) ns_req_d = 1'b0;
    if (acc_ew)            ew_req_d = 1'b1;
    else if (bus.clear_ew) ew_req_d = 1'b0;
  end

  always_ff @(posedge CCLK) begin
    if (reset) begin
      ns_req_q <= 1'b0;
      ew_req_q <= 1'b0;
    end else begin
      ns_req_q <= ns_req_d;
      ew_req_q <= ew_req_d;
    end
  end

  assign bus.btn_level   = level;
  assign bus.press_pulse = pulse;
  assign bus.ns_req      = ns_req_q;
  assign bus.ew_req      = ew_req_q;

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Bench for ped_request_conditioner: directed latency/race scenarios plus random
// button and ack traffic, all compared against a queue-based behavioural model.
module tb_ped_request_conditioner;

  localparam int DB   = 4;
  localparam int LOCK = 8;
`ifdef PED_REQ_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ped_request_conditioner_if bus ();

  ped_request_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (18),
    .LOCKOUT_CYCLES  (LOCK)
  ) dut (
    .CCLK  (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a level flips once the last DB synchronized samples all
  // disagree with it; requests follow set-over-clear with optional lockout.
  bit       m_s1 [4];
  bit       m_s2 [4];
  bit       hist [4][$];
  logic [3:0] m_level = '0;
  logic [3:0] m_pulse = '0;
  bit       m_ns, m_ew;
  int       m_lk_ns, m_lk_ew;
  bit       m_flip, m_set_ns, m_set_ew, m_srv_ns, m_srv_ew;
  bit       model_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_s1[i] = 1'b0;
        m_s2[i] = 1'b0;
        hist[i].delete();
      end
      m_level = '0;
      m_pulse = '0;
      m_ns = 1'b0;
      m_ew = 1'b0;
      m_lk_ns = 0;
      m_lk_ew = 0;
    end else begin
      m_set_ns = m_pulse[1] | m_pulse[3];
      m_set_ew = m_pulse[0] | m_pulse[2];
      m_srv_ns = bus.clear_ns && m_ns;
      m_srv_ew = bus.clear_ew && m_ew;
      if (LOCK_EN) begin
        if (m_lk_ns > 0 || m_srv_ns) m_set_ns = 1'b0;
        if (m_lk_ew > 0 || m_srv_ew) m_set_ew = 1'b0;
        m_lk_ns = m_srv_ns ? LOCK : (m_lk_ns > 0 ? m_lk_ns - 1 : 0);
        m_lk_ew = m_srv_ew ? LOCK : (m_lk_ew > 0 ? m_lk_ew - 1 : 0);
      end
      if (m_set_ns) m_ns = 1'b1; else if (bus.clear_ns) m_ns = 1'b0;
      if (m_set_ew) m_ew = 1'b1; else if (bus.clear_ew) m_ew = 1'b0;
      for (int i = 0; i < 4; i++) begin
        hist[i].push_back(m_s2[i]);
        if (hist[i].size() > DB) void'(hist[i].pop_front());
        m_flip = (hist[i].size() == DB);
        for (int k = 0; k < hist[i].size(); k++)
          if (hist[i][k] == m_level[i]) m_flip = 1'b0;
        m_pulse[i] = m_flip && !m_level[i];
        if (m_flip) m_level[i] = ~m_level[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = bus.btn_raw[i];
      end
    end
  end

  always @(negedge clk) begin
    if (model_en) begin
      chk_eq("model_level", bus.btn_level, m_level);
      chk_eq("model_pulse", bus.press_pulse, m_pulse);
      chk_eq("model_ns_req", bus.ns_req, m_ns);
      chk_eq("model_ew_req", bus.ew_req, m_ew);
    end
  end

  task automatic clear_both();
    bus.clear_ns = 1'b1;
    bus.clear_ew = 1'b1;
    step(1);
    bus.clear_ns = 1'b0;
    bus.clear_ew = 1'b0;
  endtask

  int pc;

  initial begin
    bus.btn_raw  = 4'hF;
    bus.clear_ns = 1'b0;
    bus.clear_ew = 1'b0;
    rst = 1'b1;

    // 1. reset with all buttons held
    step(3);
    chk_eq("rst_level", bus.btn_level, 4'h0);
    chk_eq("rst_pulse", bus.press_pulse, 4'h0);
    chk_eq("rst_ns", bus.ns_req, 0);
    chk_eq("rst_ew", bus.ew_req, 0);
    model_en = 1'b1;
    rst = 1'b0;
    step(6);
    chk_eq("rst_lat_pulse", bus.press_pulse, 4'hF);
    chk_eq("rst_lat_ns_early", bus.ns_req, 0);
    chk_eq("rst_lat_ew_early", bus.ew_req, 0);
    step(1);
    chk_eq("rst_lat_ns", bus.ns_req, 1);
    chk_eq("rst_lat_ew", bus.ew_req, 1);
    bus.btn_raw = 4'h0;
    step(8);
    clear_both();
    chk_eq("clr_ns", bus.ns_req, 0);
    chk_eq("clr_ew", bus.ew_req, 0);
    step(12);

    // 2. clean press on BTN1
    bus.btn_raw = 4'b0010;
    step(5);
    chk_eq("press_early", bus.press_pulse, 4'h0);
    step(1);
    chk_eq("press_pulse", bus.press_pulse, 4'b0010);
    chk_eq("press_ns_early", bus.ns_req, 0);
    step(1);
    chk_eq("press_pulse_one", bus.press_pulse, 4'h0);
    chk_eq("press_ns", bus.ns_req, 1);
    chk_eq("press_ew", bus.ew_req, 0);
    step(14);
    bus.btn_raw = 4'h0;
    step(8);
    clear_both();
    step(12);

    // 3. bounce on BTN0
    pc = 0;
    for (int j = 0; j < 12; j++) begin
      bus.btn_raw[0] = ((j / 2) % 2) == 0;
      step(1);
      if (bus.press_pulse[0]) pc++;
    end
    bus.btn_raw[0] = 1'b1;
    for (int j = 0; j < 16; j++) begin
      step(1);
      if (bus.press_pulse[0]) pc++;
      if (j == 5) begin
        chk_eq("bounce_pulse", bus.press_pulse[0], 1);
        chk_eq("bounce_ew_early", bus.ew_req, 0);
      end
      if (j == 6) chk_eq("bounce_ew", bus.ew_req, 1);
    end
    chk_eq("bounce_count", pc, 1);
    bus.btn_raw = 4'h0;
    step(8);
    clear_both();
    step(12);

    // 4. clear, then clear racing a BTN3 press
    bus.btn_raw = 4'b0010;
    step(8);
    chk_eq("race_setup_ns", bus.ns_req, 1);
    bus.btn_raw = 4'h0;
    step(8);
    bus.clear_ns = 1'b1;
    step(1);
    bus.clear_ns = 1'b0;
    chk_eq("race_clear", bus.ns_req, 0);
    step(12);
    bus.btn_raw = 4'b0010;
    step(8);
    bus.btn_raw = 4'h0;
    step(8);
    chk_eq("race_setup2_ns", bus.ns_req, 1);
    bus.btn_raw = 4'b1000;
    step(6);
    chk_eq("race_pulse3", bus.press_pulse[3], 1);
    bus.clear_ns = 1'b1;
    step(1);
    bus.clear_ns = 1'b0;
    chk_eq("race_set_wins", bus.ns_req, LOCK_EN ? 0 : 1);
    bus.btn_raw = 4'h0;
    step(8);
    clear_both();
    step(12);

    // 5. reset in the middle of a BTN2 debounce
    bus.btn_raw = 4'b0100;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_eq("mid_rst_pulse", bus.press_pulse, 4'h0);
    chk_eq("mid_rst_level", bus.btn_level, 4'h0);
    step(5);
    chk_eq("mid_rst_early", bus.press_pulse[2], 0);
    step(1);
    chk_eq("mid_rst_pulse2", bus.press_pulse[2], 1);
    step(1);
    chk_eq("mid_rst_ew", bus.ew_req, 1);
    bus.btn_raw = 4'h0;
    step(8);
    clear_both();
    step(12);

    // 6. press soon after a serviced clear
    bus.btn_raw = 4'b0010;
    step(8);
    bus.btn_raw = 4'h0;
    step(8);
    bus.clear_ns = 1'b1;
    step(1);
    bus.clear_ns = 1'b0;
    chk_eq("lock_clear", bus.ns_req, 0);
    bus.btn_raw = 4'b1000;
    step(8);
    chk_eq("lock_early_press", bus.ns_req, LOCK_EN ? 0 : 1);
    step(4);
    bus.btn_raw = 4'h0;
    step(8);
    bus.btn_raw = 4'b1000;
    step(8);
    chk_eq("lock_late_press", bus.ns_req, 1);
    bus.btn_raw = 4'h0;
    step(8);
    clear_both();
    step(12);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) bus.btn_raw[b] = ~bus.btn_raw[b];
      bus.clear_ns = ($urandom_range(0, 9) == 0);
      bus.clear_ew = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step(1);
    end
    rst = 1'b0;
    bus.clear_ns = 1'b0;
    bus.clear_ew = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
